// File: rtl/add_slice.sv
// rtl/add_slice.sv - C-bit combinational adder slice with carry-in, carry-out and MSB carry-in
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_msb_cin
);

  logic [W:0] w_full;

  assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum     = w_full[W-1:0];
  assign o_cout    = w_full[W];
  // The carry that entered the top bit is recovered from that bit's sum and operands.
  assign o_msb_cin = i_a[W-1] ^ i_b[W-1] ^ w_full[W-1];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - carry-chain pipelined adder/subtractor with valid/ready handshakes
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int C = WIDTH / STAGES;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  logic [WIDTH-1:0] w_last_sum;
  logic             w_last_cout;
  logic             w_last_msb_cin;
  logic             w_last_vld;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  // One enable moves the whole pipe; it stalls only when a result is waiting unconsumed.
  assign w_en      = !r_out_valid | out_ready;
  assign in_ready  = w_en;
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;

  // Stage k adds chunk k. Stages after the first hold the operand bits not yet added
  // (skew) and the finished low sum chunks (deskew), so every chunk leaves together.
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * C;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]  w_op_a;
      logic [REM-1:0]  w_op_b;
      logic            w_ci;
      logic            w_vld;
      logic [LO+C-1:0] w_sum_acc;
      logic [C-1:0]    w_chunk;
      logic            w_cout;
      logic            w_msb_cin;

      add_slice #(.W(C)) u_slice (
        .i_a       (w_op_a[C-1:0]),
        .i_b       (w_op_b[C-1:0]),
        .i_cin     (w_ci),
        .o_sum     (w_chunk),
        .o_cout    (w_cout),
        .o_msb_cin (w_msb_cin)
      );

      if (k == 0) begin : g_head
        assign w_op_a    = a;
        assign w_op_b    = w_b_eff;
        assign w_ci      = w_cin_eff;
        assign w_vld     = in_valid;
        assign w_sum_acc = w_chunk;
      end else begin : g_body
        logic [REM-1:0] r_a;
        logic [REM-1:0] r_b;
        logic [LO-1:0]  r_s;
        logic           r_ci;
        logic           r_vld;

        // Capture the previous stage's remaining operands, finished chunks and chunk carry.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_ci  <= 1'b0;
            r_vld <= 1'b0;
          end else if (w_en) begin
            r_a   <= g_stage[k-1].w_op_a[REM+C-1:C];
            r_b   <= g_stage[k-1].w_op_b[REM+C-1:C];
            r_s   <= g_stage[k-1].w_sum_acc;
            r_ci  <= g_stage[k-1].w_cout;
            r_vld <= g_stage[k-1].w_vld;
          end
        end

        assign w_op_a    = r_a;
        assign w_op_b    = r_b;
        assign w_ci      = r_ci;
        assign w_vld     = r_vld;
        assign w_sum_acc = {w_chunk, r_s};
      end

      if (k == STAGES - 1) begin : g_tail
        assign w_last_sum     = w_sum_acc;
        assign w_last_cout    = w_cout;
        assign w_last_msb_cin = w_msb_cin;
        assign w_last_vld     = w_vld;
      end else begin : g_mid
        logic w_unused_msb_cin;
        assign w_unused_msb_cin = w_msb_cin;
      end
    end
  endgenerate

  // Output rank: holds the finished result steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_last_vld;
      r_sum       <= w_last_sum;
      r_carry     <= w_last_cout;
      r_ovf       <= w_last_msb_cin ^ w_last_cout;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed self-checking bench for pipe_adder
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int tests  = 0;
    int failed = 0;

    int          sent;
    int          got;
    logic        held_v;
    logic [15:0] held_s;

    logic [15:0] st_a [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h8000, 16'h1234, 16'hABCD, 16'h7000};
    logic [15:0] st_b [8] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h4321, 16'h1111, 16'h1000};
    logic [15:0] st_s [8] = '{16'h0002, 16'h0100, 16'h1000, 16'hFFFE, 16'h0000, 16'h5555, 16'hBCDE, 16'h8000};
    logic        st_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        st_o [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input bit ok);
        tests++;
        if (!ok) begin
            failed++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic run_single(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                              input logic tc, input logic [15:0] es, input logic ec,
                              input logic eo, input string tag);
        a         = ta;
        b         = tb;
        sub       = ts;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                check({tag, "_early_valid"}, out_valid === 1'b0);
            end else begin
                check({tag, "_valid"}, out_valid === 1'b1);
                check({tag, "_sum"}, sum === es);
                check({tag, "_carry"}, carry === ec);
                check({tag, "_ovf"}, ovf === eo);
            end
        end
        @(negedge clk);
        check({tag, "_consumed"}, out_valid === 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid === 1'b0);
        check("rst_in_ready", in_ready === 1'b1);
        check("rst_sum", sum === 16'h0000);
        check("rst_carry", carry === 1'b0);
        check("rst_ovf", ovf === 1'b0);

        rst = 1'b0;
        #1;
        check("rel_out_valid", out_valid === 1'b0);
        check("rel_in_ready", in_ready === 1'b1);
        check("rel_sum", sum === 16'h0000);

        run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_single(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_single(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, "sub_noborrow");
        run_single(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_single(16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, "add_cin");

        sent   = 0;
        got    = 0;
        held_v = 1'b0;
        held_s = '0;
        sub    = 1'b0;
        cin    = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge clk);
            if (held_v) begin
                check("stall_valid", out_valid === 1'b1);
                check("stall_sum", sum === held_s);
            end
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 8);
            a         = (sent < 8) ? st_a[sent] : 16'h0000;
            b         = (sent < 8) ? st_b[sent] : 16'h0000;
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("stream_sum_%0d", got), sum === st_s[got]);
                check($sformatf("stream_carry_%0d", got), carry === st_c[got]);
                check($sformatf("stream_ovf_%0d", got), ovf === st_o[got]);
                got++;
            end
            held_v = out_valid && !out_ready;
            held_s = sum;
            if (in_valid && in_ready) sent++;
        end
        check("stream_count", got == 8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stream_no_extra", out_valid === 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            a        = 16'h1000 + 16'(i);
            b        = 16'h0001;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid === 1'b0);
        check("mid_rst_in_ready", in_ready === 1'b1);
        check("mid_rst_sum", sum === 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_ghost", out_valid === 1'b0);
        end
        run_single(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning the number of pipeline stages the carry chain is split into; WIDTH mod STAGES SHALL be 0 and STAGES SHALL be at least 1.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning asynchronous, active-high reset.
REQ-005 SHALL have ports a and b, input, WIDTH bits each, meaning the operands.
REQ-006 SHALL have port sub, input, 1 bit, meaning the operation: 0 computes a+b+cin, 1 computes a-b.
REQ-007 SHALL have port cin, input, 1 bit, meaning the carry-in, used only when sub=0.
REQ-008 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), meaning the input handshake.
REQ-009 SHALL have port sum, output, WIDTH bits, meaning the result.
REQ-010 SHALL have ports carry and ovf, output, 1 bit each, meaning unsigned carry-out and signed overflow.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), meaning the output handshake.

Function
REQ-012 SHALL accept an operation on a rising edge when in_valid=1 and in_ready=1.
REQ-013 SHALL compute subtraction as a + ~b + 1, i.e. the effective carry-in is forced to 1 and cin is ignored.
REQ-014 SHALL use chunk width C = WIDTH/STAGES; stage k SHALL add bits [k*C +: C] using the carry registered by stage k-1, with stage 0 using the effective carry-in.
REQ-015 SHALL skew operand chunks not yet consumed, and deskew completed sum chunks, through registers so that all chunks of one operation leave together.
REQ-016 SHALL present the result with out_valid=1 exactly STAGES cycles after acceptance when there is no stall.
REQ-017 SHALL use a global advance enable en = !out_valid | out_ready; when en=0 every stage register, including valid bits, SHALL hold.
REQ-018 SHALL drive in_ready = en as a combinational function.
REQ-019 SHALL keep sum, carry and ovf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL sustain a throughput of one operation per cycle when out_ready is held at 1.
REQ-021 SHALL drive carry as the carry out of the MSB; for sub=1, carry=1 SHALL mean no borrow (a >= b unsigned).
REQ-022 SHALL drive ovf = carry into the MSB XOR carry out of the MSB.
REQ-023 SHALL wrap the sum modulo 2^WIDTH.
REQ-024 SHALL propagate bubbles: a stage whose valid bit is 0 SHALL still advance when en=1, and its data is don't-care.
REQ-025 SHALL, when a valid result is consumed in the same cycle a new input is accepted, perform both with no bubble inserted.
REQ-026 SHALL, with STAGES=1, degenerate to a single registered adder with latency 1.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear all stage valid bits, so out_valid=0 and in_ready=1.
REQ-028 SHALL, while rst=1, hold sum, carry and ovf at 0, with all data registers cleared.
REQ-029 SHALL discard in-flight operations on reset mid-operation; no result from an operation accepted before reset SHALL ever appear.
REQ-030 SHALL accept inputs on the first rising edge after rst deasserts.

Structure
REQ-031 SHALL place no package; WIDTH and STAGES are module parameters only, with no shared typedefs needed.
REQ-032 SHALL use one sub-module, add_slice, as a parametrised C-bit combinational adder with cin, producing sum, cout and msb-carry-in, instantiated STAGES times via generate.

Verification
REQ-033 SHALL verify reset release: out_valid=0, in_ready=1, sum=0.
REQ-034 SHALL verify addition: WIDTH=16, STAGES=4, a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> after 4 cycles sum=16'h0000, carry=1, ovf=0.
REQ-035 SHALL verify signed overflow on add: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, carry=0, ovf=1.
REQ-036 SHALL verify subtraction: a=16'h0003, b=16'h0005, sub=1, cin=1 -> sum=16'hFFFE, carry=0 (borrow), ovf=0; cin ignored.
REQ-037 SHALL verify backpressure: stream 8 back-to-back adds with out_ready toggled 1/0 each cycle -> all 8 results delivered in order, each correct, none dropped or duplicated, sum stable during stalls.
REQ-038 SHALL verify reset mid-flight: accept 3 operations, assert rst for 1 cycle -> out_valid stays 0 until a new accept, after which exactly 4 cycles pass to the next valid result.
